// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and default constants for the dmem_sync data memory.
//   dmem_state_e : controller state (CLEAR = zero-fill after reset, RUN = serve)
//   DMEM_DW      : default data word width
//   DMEM_AW      : default address width
// -----------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } dmem_state_e;

   localparam int DMEM_DW = 8;
   localparam int DMEM_AW = 8;

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH x DW storage with one clocked write port and one registered read port.
// The read register returns the contents as of the clock edge (read-before-
// write), or zero when the caller flags the access as out of range.
//
// Ports
//   clk, rst_n  : clock, async active-low reset (read register only)
//   we_i        : write enable
//   waddr_i     : write address (must be < DEPTH when we_i is set)
//   wdata_i     : write data
//   re_i        : load the read register this edge
//   rzero_i     : load zero instead of array contents
//   raddr_i     : read address (ignored when rzero_i is set)
//   rdata_o     : registered read data, holds between loads
// -----------------------------------------------------------------------------
module dmem_array #(
   parameter int DW    = 8,
   parameter int AW    = 8,
   parameter int DEPTH = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic          rzero_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem [0:DEPTH-1];
   logic [DW-1:0] rdata_q;

   // NOTE: the storage array has no reset so it maps onto plain RAM; a
   // deterministic post-reset state comes from the controller's clear sweep.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   // NOTE: non-blocking assignments on both ports mean a read at the same edge
   // as a write observes the old word, and neither block depends on the
   // evaluation order of the other.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= rzero_i ? '0 : mem[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule : dmem_array

// File: rtl/dmem_sync.sv
// -----------------------------------------------------------------------------
// dmem_sync
// Synchronous data memory for the load/store stage. One valid/ready request
// port, 1-cycle registered read response, out-of-range detection, and an
// optional hardware zero-fill after reset.
//
// Build option
//   DMEM_SYNC_CLEAR_EN : when defined, edges 1..DEPTH after reset write zero to
//                        every word before requests are accepted. When
//                        undefined, the block is ready from edge 1 and memory
//                        contents are undefined until written.
//
// Ports
//   clk, rst_n : clock, async active-low reset
//   req_valid  : request present          req_ready : request accepted this cycle
//   req_we     : 1 = write, 0 = read      req_addr  : word address
//   req_wdata  : write data
//   rsp_valid  : read response pulse      rsp_rdata : read data (holds otherwise)
//   rsp_err    : previous accepted request addressed >= DEPTH
//   init_done  : clear finished, memory usable
// -----------------------------------------------------------------------------
module dmem_sync
   import dmem_pkg::*;
#(
   parameter int DW    = DMEM_DW,
   parameter int AW    = DMEM_AW,
   parameter int DEPTH = 2 ** AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          init_done
);

   // One extra bit so DEPTH == 2**AW is representable and the range check
   // compares at full address width without wrap-around.
   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   dmem_state_e   state_q, state_d;
   logic          accept;
   logic          in_range;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_err_q, rsp_err_d;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;

   assign req_ready = (state_q == RUN);
   assign init_done = (state_q == RUN);
   assign accept    = req_valid && req_ready;
   assign in_range  = ({1'b0, req_addr} < DEPTH_W);

`ifdef DMEM_SYNC_CLEAR_EN
   logic [AW-1:0] clr_ptr_q, clr_ptr_d;
   logic          clr_last;

   assign clr_last = ({1'b0, clr_ptr_q} == (DEPTH_W - 1'b1));
`endif

   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      mem_we    = accept && req_we && in_range;
      mem_waddr = req_addr;
      mem_wdata = req_wdata;
`ifdef DMEM_SYNC_CLEAR_EN
      clr_ptr_d = clr_ptr_q;
`endif
      case (state_q)
         CLEAR: begin
`ifdef DMEM_SYNC_CLEAR_EN
            // Zero-fill sweep: one word per edge, leave on the last word.
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_last) begin
               state_d = RUN;
            end
`else
            // Without the sweep, CLEAR is only the reset holding state.
            state_d = RUN;
`endif
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   assign rsp_valid_d = accept && !req_we;
   assign rsp_err_d   = accept && !in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= CLEAR;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

`ifdef DMEM_SYNC_CLEAR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_ptr_q <= '0;
      end else begin
         clr_ptr_q <= clr_ptr_d;
      end
   end
`endif

   // Out-of-range reads load zero into the read register, so rsp_rdata both
   // reports 0 and keeps holding 0 afterwards.
   dmem_array #(
      .DW    (DW),
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wdata_i (mem_wdata),
      .re_i    (rsp_valid_d),
      .rzero_i (!in_range),
      .raddr_i (req_addr),
      .rdata_o (rsp_rdata)
   );

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;

endmodule : dmem_sync

// File: tb/tb_dmem_sync.sv
// -----------------------------------------------------------------------------
// tb_dmem_sync
// Two instances: dut A with full depth (256 words) and dut B with DEPTH = 200
// for out-of-range addresses. Stimulus pushes expected responses into a queue
// per instance; a negedge monitor pops and compares whenever an instance shows
// rsp_valid or rsp_err, including the cycle the response must appear in.
// -----------------------------------------------------------------------------
module tb_dmem_sync;

   localparam int DW = 8;
   localparam int AW = 8;

`ifdef DMEM_SYNC_CLEAR_EN
   localparam int CLR_A = 256;
   localparam int CLR_B = 200;
`else
   localparam int CLR_A = 1;
   localparam int CLR_B = 1;
`endif

   typedef struct {
      int          due;
      bit          valid;
      logic [7:0]  rdata;
      bit          err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;

   logic          a_valid = 1'b0, a_we = 1'b0;
   logic [AW-1:0] a_addr = '0;
   logic [DW-1:0] a_wdata = '0;
   logic          a_ready, a_rsp_valid, a_rsp_err, a_init;
   logic [DW-1:0] a_rsp_rdata;

   logic          b_valid = 1'b0, b_we = 1'b0;
   logic [AW-1:0] b_addr = '0;
   logic [DW-1:0] b_wdata = '0;
   logic          b_ready, b_rsp_valid, b_rsp_err, b_init;
   logic [DW-1:0] b_rsp_rdata;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t qa[$];
   exp_t qb[$];

   dmem_sync #(.DW(DW), .AW(AW)) u_dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (a_valid),
      .req_ready (a_ready),
      .req_we    (a_we),
      .req_addr  (a_addr),
      .req_wdata (a_wdata),
      .rsp_valid (a_rsp_valid),
      .rsp_rdata (a_rsp_rdata),
      .rsp_err   (a_rsp_err),
      .init_done (a_init)
   );

   dmem_sync #(.DW(DW), .AW(AW), .DEPTH(200)) u_dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (b_valid),
      .req_ready (b_ready),
      .req_we    (b_we),
      .req_addr  (b_addr),
      .req_wdata (b_wdata),
      .rsp_valid (b_rsp_valid),
      .rsp_rdata (b_rsp_rdata),
      .rsp_err   (b_rsp_err),
      .init_done (b_init)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Compares one presented response against the head of the queue.
   task automatic monitor_rsp(input string name, input logic v, input logic [7:0] d,
                              input logic e, input exp_t ev, input bit have);
      logic [31:0] act, exp;
      if (!have) begin
         check({name, "_unexpected"}, {30'd0, v, e}, 32'd0);
      end else begin
         act = {cyc[13:0], 8'd0, v, e, (ev.valid ? d : 8'h00)};
         exp = {ev.due[13:0], 8'd0, ev.valid, ev.err, ev.rdata};
         check({name, "_rsp"}, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t ev;
      bit   have;
      if (rst_n && (a_rsp_valid || a_rsp_err)) begin
         have = (qa.size() > 0);
         if (have) ev = qa.pop_front();
         monitor_rsp("a", a_rsp_valid, a_rsp_rdata, a_rsp_err, ev, have);
      end
      if (rst_n && (b_rsp_valid || b_rsp_err)) begin
         have = (qb.size() > 0);
         if (have) ev = qb.pop_front();
         monitor_rsp("b", b_rsp_valid, b_rsp_rdata, b_rsp_err, ev, have);
      end
   end

   // Drives one request for one cycle (entered and left at posedge + 1).
   task automatic issue(input bit sel_b, input bit we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rdata,
                        input bit exp_err);
      exp_t ev;
      ev.due   = cyc + 1;
      ev.valid = !we;
      ev.rdata = exp_rdata;
      ev.err   = exp_err;
      if (!we || exp_err) begin
         if (sel_b) qb.push_back(ev);
         else       qa.push_back(ev);
      end
      if (sel_b) begin
         b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
      end else begin
         a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
      end
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Releases reset and counts edges until each instance raises init_done.
   task automatic release_and_measure(input string name);
      int na, nb, n;
      na = 0; nb = 0; n = 0;
      rst_n = 1'b1;
      while ((na == 0 || nb == 0) && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
         if (na == 0 && a_init) na = n;
         if (nb == 0 && b_init) nb = n;
      end
      check({name, "_clear_len_a"}, na, CLR_A);
      check({name, "_clear_len_b"}, nb, CLR_B);
      check({name, "_ready_a"}, {31'd0, a_ready}, 32'd1);
   endtask

   initial begin
      // Reset values while rst_n is low.
      #1;
      check("reset_outputs_a", {27'd0, a_ready, a_rsp_valid, a_rsp_err, a_init, 1'b0}, 32'd0);
      check("reset_rdata_a", {24'd0, a_rsp_rdata}, 32'd0);
      check("reset_outputs_b", {28'd0, b_ready, b_rsp_valid, b_rsp_err, b_init}, 32'd0);
      idle(3);

      release_and_measure("initial");

`ifdef DMEM_SYNC_CLEAR_EN
      issue(1'b0, 1'b0, 8'h7F, 8'h00, 8'h00, 1'b0);
      idle(1);
`endif

      // Write then read on the very next edge, then a hold cycle.
      issue(1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0);
      issue(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
      idle(1);
      check("rdata_hold_a", {23'd0, a_rsp_valid, a_rsp_rdata}, {23'd0, 1'b0, 8'hA5});

      // Sustained stream: 256 writes then 256 reads, no gaps.
      for (int i = 0; i < 256; i++) begin
         issue(1'b0, 1'b1, 8'(i), 8'(i) ^ 8'h3C, 8'h00, 1'b0);
      end
      for (int i = 0; i < 256; i++) begin
         issue(1'b0, 1'b0, 8'(i), 8'h00, 8'(i) ^ 8'h3C, 1'b0);
      end
      idle(2);

      // Out of range on the 200-word instance.
      issue(1'b1, 1'b1, 8'hC7, 8'h33, 8'h00, 1'b0);
      issue(1'b1, 1'b1, 8'hC8, 8'h55, 8'h00, 1'b1);
      issue(1'b1, 1'b0, 8'hC8, 8'h00, 8'h00, 1'b1);
      issue(1'b1, 1'b0, 8'hC7, 8'h00, 8'h33, 1'b0);
      issue(1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1);
      idle(1);
      check("err_clears_b", {30'd0, b_rsp_valid, b_rsp_err}, 32'd0);
      check("oor_rdata_hold_b", {24'd0, b_rsp_rdata}, 32'd0);

      // Reset during a pending read response: response vanishes at once.
      a_valid = 1'b1; a_we = 1'b0; a_addr = 8'h10;
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      check("pending_rsp_a", {31'd0, a_rsp_valid}, 32'd1);
      #1;
      rst_n = 1'b0;
      qa.delete();
      qb.delete();
      #1;
      check("async_drop_a", {29'd0, a_rsp_valid, a_rsp_err, a_init}, 32'd0);
      idle(2);

      // Release, abort the clear at edge 100, release again.
      rst_n = 1'b1;
      idle(100);
      rst_n = 1'b0;
      idle(2);
      release_and_measure("midclear");

`ifdef DMEM_SYNC_CLEAR_EN
      for (int i = 0; i < 256; i++) begin
         issue(1'b0, 1'b0, 8'(i), 8'h00, 8'h00, 1'b0);
      end
`endif
      issue(1'b0, 1'b1, 8'h00, 8'h3C, 8'h00, 1'b0);
      issue(1'b0, 1'b0, 8'h00, 8'h00, 8'h3C, 1'b0);
      idle(3);

      check("qa_drained", qa.size(), 32'd0);
      check("qb_drained", qb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_dmem_sync

// File: doc/dmem_sync.md
# dmem_sync

Parametrised synchronous data memory for the datapath load/store stage: one request port with valid/ready handshake, registered read data with a 1-cycle response, and a hardware clear sequence after reset. It replaces the fixed 8-bit × 256 unclocked-read memory. It also adds configurable width and depth, out-of-range detection, and a deterministic post-reset state.

## Interface
- DW, 8, data word width in bits (≥1)
- AW, 8, address width in bits (≥1)
- DEPTH, 2**AW, number of words; must satisfy 1 ≤ DEPTH ≤ 2**AW
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- req_valid  input  1  request present this cycle
- req_ready  output  1  block accepts a request this cycle
- req_we  input  1  1 = write, 0 = read
- req_addr  input  AW  word address
- req_wdata  input  DW  write data
- rsp_valid  output  1  read response valid (1-cycle pulse)
- rsp_rdata  output  DW  read data
- rsp_err  output  1  accepted request addressed ≥ DEPTH (valid with rsp_valid for reads; pulse for writes)
- init_done  output  1  clear sequence finished; memory usable

## Operation
- **Handshake:** a request is accepted on a rising edge where req_valid && req_ready. Only one request is handled per cycle.
- **FSM states:** CLEAR, RUN.
  - Reset forces CLEAR with clear pointer = 0.
  - In CLEAR, each edge writes 0 to the word at the pointer and increments it. On the edge that writes DEPTH-1, the FSM moves to RUN.
  - In RUN the FSM stays in RUN until rst_n falls.
- **req_ready:** 1 only in RUN. It never depends combinationally on req_valid.
- **Accepted write, in range:** the word is updated at the accepting edge. No rsp_valid is produced.
- **Accepted read, in range:** rsp_valid = 1 in the next cycle, with rsp_rdata = word contents as of the accepting edge, before any write at that same edge. Only one request per cycle, so no same-cycle read/write collision exists.
- **Read-after-write:** a read accepted the cycle after a write to the same address returns the new data.
- **Out of range (addr ≥ DEPTH):**
  - Write: dropped, memory unchanged, rsp_err = 1 for one cycle.
  - Read: rsp_valid = 1, rsp_rdata = 0, rsp_err = 1.
- **Hold behaviour:** rsp_rdata holds its last value while rsp_valid = 0. rsp_err is 0 whenever no accepted request occurred in the previous cycle.
- **Widths:** addresses compare unsigned, at full AW width, against DEPTH. There is no wrap-around and no truncation.

## Timing
- **Reset values:** req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, init_done 0; FSM in CLEAR.
- **Clear length:** with the macro enabled, edges 1..DEPTH after rst_n deassertion clear words 0..DEPTH-1. init_done and req_ready rise after edge DEPTH, so the first request can be accepted on edge DEPTH+1.
- **Read latency:** exactly 1 cycle. Throughput is 1 request per cycle, sustained, with any read/write mix.
- **Response flow control:** none. The consumer must sample rsp_* in the cycle it is valid.
- **Reset mid-clear:** clearing restarts from address 0 and the full DEPTH cycles are repeated.
- **Reset mid-read:** the pending response is discarded and rsp_valid goes 0 immediately (asynchronous).
- **init_done:** once high, stays high until reset.

## Configuration
- Macro: `DMEM_SYNC_CLEAR_EN`.
- **Defined:** the CLEAR state and clear pointer exist as described above, and the memory reads all zeros after init.
- **Undefined:**
  - The CLEAR state is removed, and the FSM enters RUN on the first edge after rst_n deassertion.
  - init_done and req_ready are 1 from edge 1.
  - Memory contents are undefined until written.
  - All other behaviour is identical.

## Structure
- **Shared package `dmem_pkg`:** state enum `dmem_state_e` {CLEAR, RUN}, default constants DMEM_DW = 8 and DMEM_AW = 8.
- **Sub-module `dmem_array`:** a DEPTH × DW storage array with one clocked write port and one registered read port, with no reset on the array contents.
- **Top-level logic:** handshake, FSM, clear pointer, range check, and response registers.

## Test plan
- **Reset and clear (DW=8, AW=8, macro on):** deassert rst_n → init_done and req_ready rise after exactly 256 edges; read of addr 0x7F → rsp_valid next cycle, rsp_rdata 0x00.
- **Write then back-to-back read:** write 0xA5 to 0x10, then read 0x10 on the very next edge → rsp_rdata 0xA5, rsp_err 0.
- **Sustained stream:** 256 consecutive writes of data = addr ^ 0x3C, then 256 consecutive reads → rsp_valid high every cycle, all data matches, no bubbles.
- **Out of range (DEPTH=200):**
  - Write 0x55 to addr 0xC8 → rsp_err pulse, no rsp_valid.
  - Read 0xC8 → rsp_valid 1, rsp_rdata 0x00, rsp_err 1.
  - Read 0xC7 → rsp_err 0.
- **Reset mid-clear:** assert rst_n low at edge 100 of the clear, then release → init_done rises exactly 256 edges after re-release; words 0..255 all read 0.
- **Macro off:** init_done = 1 on edge 1; write 0x3C to 0x00 then read 0x00 → 0x3C.
